// File: rtl/pipe_pkg.sv
// Shared types and per-stage field widths for the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // IF/ID: pc 32 + instruction 32; single "slot live" control bit.
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    // ID/EX: rs1 32 + rs2 32 + imm 32 + rd 5; ALU op and memory controls.
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 101;
    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 69;
    // MEM/WB: load data 32 + ALU result 32 + rd 5; RegWrite and MemReg.
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    function automatic logic holds_beat(input pipe_state_t s);
        return (s != EMPTY);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and an optional
// skid entry; the control field reads zero on every empty or squashed slot.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    pipe_state_t       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              acc_s;
    logic              drn_s;

    assign out_valid_o = holds_beat(state_q);
    assign ctrl_o      = main_ctrl_q;
    assign data_o      = main_data_q;

    assign acc_s = start_i & in_valid_i & in_ready_o & ~flush_i;
    assign drn_s = start_i & out_valid_o & out_ready_i & ~flush_i;

    if (SKID != 0) begin : g_skid
        logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;
        logic              in_ready_q, in_ready_d;

        assign in_ready_o = in_ready_q;

        // Two-entry next-state: main is the head, skid holds the younger beat.
        always_comb begin
            state_d     = state_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
            if (flush_i) begin
                state_d     = EMPTY;
                main_ctrl_d = {CTRL_W{1'b0}};
                skid_ctrl_d = {CTRL_W{1'b0}};
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (acc_s) begin
                            state_d     = ONE;
                            main_ctrl_d = ctrl_i;
                            main_data_d = data_i;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                    ONE: begin
                        if (acc_s && drn_s) begin
                            main_ctrl_d = ctrl_i;
                            main_data_d = data_i;
                        end else if (acc_s) begin
                            state_d     = TWO;
                            skid_ctrl_d = ctrl_i;
                            skid_data_d = data_i;
                        end else if (drn_s) begin
                            state_d     = EMPTY;
                            main_ctrl_d = {CTRL_W{1'b0}};
                        end else begin
                            state_d = ONE;
                        end
                    end
                    TWO: begin
                        if (drn_s) begin
                            state_d     = ONE;
                            main_ctrl_d = skid_ctrl_q;
                            main_data_d = skid_data_q;
                            skid_ctrl_d = {CTRL_W{1'b0}};
                        end else begin
                            state_d = TWO;
                        end
                    end
                    default: begin
                        state_d     = EMPTY;
                        main_ctrl_d = {CTRL_W{1'b0}};
                        skid_ctrl_d = {CTRL_W{1'b0}};
                    end
                endcase
            end
            // Ready is a flop: it only drops once both entries are occupied.
            in_ready_d = (state_d != TWO);
        end

        // State and storage update with synchronous reset.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q     <= EMPTY;
                main_ctrl_q <= {CTRL_W{1'b0}};
                main_data_q <= {DATA_W{1'b0}};
                skid_ctrl_q <= {CTRL_W{1'b0}};
                skid_data_q <= {DATA_W{1'b0}};
                in_ready_q  <= 1'b1;
            end else begin
                state_q     <= state_d;
                main_ctrl_q <= main_ctrl_d;
                main_data_q <= main_data_d;
                skid_ctrl_q <= skid_ctrl_d;
                skid_data_q <= skid_data_d;
                in_ready_q  <= in_ready_d;
            end
        end
    end else begin : g_single
        assign in_ready_o = ~out_valid_o | out_ready_i;

        // Single-entry next-state: a simultaneous drain and accept replaces the head.
        always_comb begin
            state_d     = state_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            if (flush_i) begin
                state_d     = EMPTY;
                main_ctrl_d = {CTRL_W{1'b0}};
            end else if (acc_s) begin
                state_d     = ONE;
                main_ctrl_d = ctrl_i;
                main_data_d = data_i;
            end else if (drn_s) begin
                state_d     = EMPTY;
                main_ctrl_d = {CTRL_W{1'b0}};
            end else begin
                state_d = state_q;
            end
        end

        // State and storage update with synchronous reset.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q     <= EMPTY;
                main_ctrl_q <= {CTRL_W{1'b0}};
                main_data_q <= {DATA_W{1'b0}};
            end else begin
                state_q     <= state_d;
                main_ctrl_q <= main_ctrl_d;
                main_data_q <= main_data_d;
            end
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register with valid/ready handshake, flush, and an optional skid entry. It replaces hand-written inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block carrying a control field and a data field. The control field is forced to zero on bubbles and flushes, so a squashed slot never writes the register file or memory. In skid mode it sustains one transfer per cycle with fully registered `in_ready_o`.

## Interface
- `CTRL_W`, default 4: control bits (e.g. RegWrite, MemReg, MemRead, MemWrite); zeroed on bubble/flush.
- `DATA_W`, default 69: payload bits (e.g. ALU result 32 + rs2 data 32 + rd addr 5).
- `SKID`, default 1: 1 = two-entry skid buffer, registered ready; 0 = single entry, combinational ready.
- Ports:
  - `clk_i` input 1: clock; all state updates on rising edge.
  - `rst_i` input 1: reset; synchronous and active-high.
  - `start_i` input 1: global run enable; low freezes the stage.
  - `flush_i` input 1: squash every held entry and the incoming beat.
  - `in_valid_i` input 1: upstream beat valid.
  - `in_ready_o` output 1: stage can accept a beat.
  - `ctrl_i` input CTRL_W: upstream control field.
  - `data_i` input DATA_W: upstream payload.
  - `out_valid_o` output 1: head entry valid.
  - `out_ready_i` input 1: downstream accepts the head entry.
  - `ctrl_o` output CTRL_W: head control; 0 whenever `out_valid_o`=0.
  - `data_o` output DATA_W: head payload; holds its last value when invalid.

## Operation
- Accept: `acc = start_i & in_valid_i & in_ready_o & ~flush_i`. Drain: `drn = start_i & out_valid_o & out_ready_i & ~flush_i`.
- Priority: `rst_i` > `flush_i` > `start_i`=0 (hold everything) > handshake.
- SKID=1 states:
  - EMPTY: `acc` loads main entry, then ONE.
  - ONE: `acc & drn` replaces main with input, stays ONE. `acc & ~drn` loads skid entry, then TWO. `~acc & drn` goes to EMPTY.
  - TWO: `drn` moves skid to main, then ONE. No accept is possible, because `in_ready_o`=0.
- SKID=1 `in_ready_o` is registered: 1 in EMPTY/ONE, 0 in TWO.
- SKID=0: single entry, with `in_ready_o = ~out_valid_o | out_ready_i`, combinational.
  - `acc` loads the entry.
  - `drn & ~acc` empties it.
- Flush: next state EMPTY; `out_valid_o`=0 and `ctrl_o`=0 from the next cycle. The incoming beat is dropped even if `in_valid_i` is high. `data_o` is not cleared.
- Reset: state EMPTY, `out_valid_o`=0, `ctrl_o`=0, `data_o`=0, skid contents=0, `in_ready_o`=1 after the reset edge.
- `start_i`=0: no accept and no drain. Outputs stay stable. `in_ready_o` keeps its registered value, but `acc` is gated off.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.

## Timing
- Latency: one cycle from an accept edge to `out_valid_o`=1 with that beat's `ctrl_o`/`data_o`.
- Throughput: one beat per cycle in both modes while `out_ready_i`=1.
- SKID=1 ready path: `out_ready_i` falls while ONE and `acc` is high → next cycle TWO, `in_ready_o`=0. No beat is lost: the stall propagates upstream one cycle late.
- After a drain in TWO, `in_ready_o` returns to 1 on the next edge.
- Flush in the same cycle as `acc` or `drn`: flush wins and neither transfer counts. Downstream must treat the flushed head as never delivered.
- Reset asserted mid-stream (state TWO): next edge gives EMPTY with all outputs at their reset values.

## Structure
- Shared package `pipe_pkg`:
  - `typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t`.
  - Stage width localparams: `EXMEM_CTRL_W`=4, `EXMEM_DATA_W`=69, and the equivalents for IF/ID, ID/EX, MEM/WB.
- No sub-module. The two storage entries and the FSM are inline, and SKID is selected with a generate branch.

## Test plan
- Reset / fill / drain: reset then `in_valid_i`=1 with ctrl=4'b1010, data=69'h5 → next cycle `out_valid_o`=1, ctrl_o=4'b1010, data_o=5. With `out_ready_i`=1 and no input → one cycle later `out_valid_o`=0, ctrl_o=0, data_o=5.
- Back-pressure (SKID=1): stream data 1,2,3,4 while `out_ready_i`=0 from cycle 2 →
  - `in_ready_o` goes 0 after beat 2 is accepted.
  - After release, the output sequence is exactly 1,2,3,4 with no duplicates.
- Full throughput: 16 beats in consecutive cycles with `out_ready_i`=1 → 16 consecutive output cycles, `in_ready_o` constantly 1, in both SKID=0 and SKID=1.
- Flush in TWO while `in_valid_i`=1 with data=9 → next cycle `out_valid_o`=0, ctrl_o=0, `in_ready_o`=1; beat 9 never appears.
- `start_i`=0 for 3 cycles while TWO with `out_ready_i`=1 → outputs unchanged for 3 cycles. Once `start_i` returns to 1, the drain resumes in order.
- Reset mid-stream: `rst_i` pulsed for 1 cycle in TWO → next cycle `out_valid_o`=0, ctrl_o=0, data_o=0, `in_ready_o`=1.
